// File: rtl/problem_one_pkg.sv
// problem_one_pkg: shared constants for the dual-rail prime detector
package problem_one_pkg;
  localparam logic [15:0] MINTERM_MASK = 16'h28AC;
  function automatic logic is_prime4(input logic [3:0] v);
    return MINTERM_MASK[v];
  endfunction
endpackage

// File: rtl/problem_one_rail_checker.sv
// problem_one_rail_checker: flags any dual-rail pair whose rails agree
module problem_one_rail_checker
  import problem_one_pkg::*;
(
  input  logic [3:0] i_t,
  input  logic [3:0] i_f,
  output logic       o_bad
);
  assign o_bad = |(i_t ~^ i_f);
endmodule

// File: rtl/problem_one.sv
// problem_one: dual-rail 4-bit prime detector with registered output and rail-error flag
module problem_one
  import problem_one_pkg::*;
#(
  parameter bit STICKY_ERR = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic an,
  input  logic bn,
  input  logic cn,
  input  logic dn,
  output logic out,
  output logic out_q,
  output logic rail_err
);
  logic w_rail_bad;
  logic r_out_q;
  logic r_rail_err;
  // complement literals come from the n-rails, never from inverting the true rails
  assign out = (an & bn & c) | (an & b & d) | (bn & c & d) | (b & cn & d);
  problem_one_rail_checker u_chk (
    .i_t  ({a, b, c, d}),
    .i_f  ({an, bn, cn, dn}),
    .o_bad(w_rail_bad)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q    <= 1'b0;
      r_rail_err <= 1'b0;
    end else begin
      r_out_q    <= out;
      r_rail_err <= STICKY_ERR ? (r_rail_err | w_rail_bad) : w_rail_bad;
    end
  end
  assign out_q    = r_out_q;
  assign rail_err = r_rail_err;
endmodule

// File: tb/tb_problem_one.sv
// tb_problem_one: scoreboard bench for sticky and non-sticky problem_one instances
module tb_problem_one;
  import problem_one_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 0, b = 0, c = 0, d = 0, an = 1, bn = 1, cn = 1, dn = 1;
  logic out0, out_q0, re0, out1, out_q1, re1;
  int n_chk = 0;
  int n_err = 0;
  logic q[$];
  logic [3:0] gray [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                            4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
  logic [15:0] gray_exp = 16'b0011011001000100;
  always #10 clk = ~clk;
  problem_one #(.STICKY_ERR(1'b1)) u_s (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .an(an), .bn(bn), .cn(cn), .dn(dn), .out(out0), .out_q(out_q0), .rail_err(re0)
  );
  problem_one #(.STICKY_ERR(1'b0)) u_n (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .an(an), .bn(bn), .cn(cn), .dn(dn), .out(out1), .out_q(out_q1), .rail_err(re1)
  );
  task automatic check(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask
  task automatic step(input logic [3:0] t, input logic [3:0] f, input logic exp);
    logic e;
    @(negedge clk);
    {a, b, c, d} = t;
    {an, bn, cn, dn} = f;
    #1;
    check("out_s", out0, exp);
    check("out_n", out1, exp);
    q.push_back(exp);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check("sb_empty", 1'b1, 1'b0);
    end else begin
      e = q.pop_front();
      check("out_q_s", out_q0, e);
      check("out_q_n", out_q1, e);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    {a, b, c, d} = 4'b0000;
    {an, bn, cn, dn} = 4'b1111;
    #5;
    check("rst_out_q_s", out_q0, 1'b0);
    check("rst_out_q_n", out_q1, 1'b0);
    check("rst_re_s", re0, 1'b0);
    check("rst_re_n", re1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("pre_edge_out_q", out_q0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(gray[i], ~gray[i], gray_exp[15-i]);
      check("gray_re_s", re0, 1'b0);
      check("gray_re_n", re1, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      step(v, ~v, MINTERM_MASK[v]);
    end
    step(4'b0010, 4'b1111, 1'b1);
    check("inj_re_s", re0, 1'b1);
    check("inj_re_n", re1, 1'b1);
    step(4'b0010, 4'b1101, 1'b1);
    check("restore_re_s", re0, 1'b1);
    check("restore_re_n", re1, 1'b0);
    step(4'b0010, 4'b1101, 1'b1);
    check("hold_re_s", re0, 1'b1);
    check("hold_re_n", re1, 1'b0);
    #4;
    rst_n = 1'b0;
    #1;
    check("arst_out_q_s", out_q0, 1'b0);
    check("arst_out_q_n", out_q1, 1'b0);
    check("arst_re_s", re0, 1'b0);
    {a, b, c, d} = 4'b0101;
    {an, bn, cn, dn} = 4'b1010;
    #1;
    check("rst_track_out", out0, 1'b1);
    {a, b, c, d} = 4'b0100;
    {an, bn, cn, dn} = 4'b1011;
    #1;
    check("rst_track_out0", out0, 1'b0);
    @(negedge clk);
    {a, b, c, d} = 4'b1101;
    {an, bn, cn, dn} = 4'b0010;
    rst_n = 1'b1;
    #1;
    check("rel_out", out0, 1'b1);
    check("rel_out_q", out_q0, 1'b0);
    @(posedge clk);
    #1;
    check("rel_edge_out_q_s", out_q0, 1'b1);
    check("rel_edge_out_q_n", out_q1, 1'b1);
    check("rel_edge_re_s", re0, 1'b0);
    check("rel_edge_re_n", re1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
